// File: rtl/apb_pwm_bank.sv
`default_nettype none
// =============================================================================
// apb_pwm_bank : APB3 slave, NUM_CH double-buffered PWM outputs on one shared prescaler/period counter
// Rev 1.0
// =============================================================================
module apb_pwm_bank #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 16,
    parameter int PRE_WIDTH = 8
) (
    input  logic              SYSCLK,
    input  logic              NSYSRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [7:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [NUM_CH-1:0] PWM_OUT,
    output logic              IRQ
);

    localparam logic [5:0] c_idx_ctrl   = 6'd0;
    localparam logic [5:0] c_idx_period = 6'd1;
    localparam logic [5:0] c_idx_pre    = 6'd2;
    localparam logic [5:0] c_idx_status = 6'd3;
    localparam logic [5:0] c_idx_duty0  = 6'd4;

    logic [5:0]        w_idx;
    logic              w_access;
    logic              w_wr;
    logic              w_rd;
    logic              w_hit_ctrl;
    logic              w_hit_period;
    logic              w_hit_pre;
    logic              w_hit_status;
    logic              w_hit_any;
    logic [NUM_CH-1:0] w_hit_duty;
    logic              w_tick;
    logic              w_wrap;
    logic              w_load;
    logic              w_unused;

    logic                 en_q, en_d;
    logic                 irq_en_q, irq_en_d;
    logic [NUM_CH-1:0]    ch_en_q, ch_en_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] period_act_q, period_act_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [PRE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic                 wrap_q, wrap_d;
    logic                 irq_q, irq_d;
    logic [NUM_CH-1:0]    pwm_q, pwm_d;
    logic [CNT_WIDTH-1:0] duty_q     [NUM_CH];
    logic [CNT_WIDTH-1:0] duty_d     [NUM_CH];
    logic [CNT_WIDTH-1:0] duty_act_q [NUM_CH];
    logic [CNT_WIDTH-1:0] duty_act_d [NUM_CH];

    assign w_idx        = PADDR[7:2];
    assign w_access     = PSEL & PENABLE;
    assign w_wr         = w_access & PWRITE;
    assign w_rd         = w_access & ~PWRITE;
    assign w_hit_ctrl   = (w_idx == c_idx_ctrl);
    assign w_hit_period = (w_idx == c_idx_period);
    assign w_hit_pre    = (w_idx == c_idx_pre);
    assign w_hit_status = (w_idx == c_idx_status);
    assign w_hit_any    = w_hit_ctrl | w_hit_period | w_hit_pre | w_hit_status | (|w_hit_duty);
    assign w_unused     = ^{PADDR[1:0], PWDATA};

    always_comb begin
        w_hit_duty = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_hit_duty[i] = (w_idx == (c_idx_duty0 + 6'(i)));
        end
    end

    // Register file writes and the WRAP flag (a wrap beats a same-cycle clear)
    always_comb begin
        en_d       = en_q;
        irq_en_d   = irq_en_q;
        ch_en_d    = ch_en_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        for (int i = 0; i < NUM_CH; i++) begin
            duty_d[i] = duty_q[i];
        end
        if (w_wr) begin
            if (w_hit_ctrl) begin
                en_d     = PWDATA[0];
                irq_en_d = PWDATA[1];
                ch_en_d  = PWDATA[8 +: NUM_CH];
            end
            if (w_hit_period) begin
                period_d = PWDATA[CNT_WIDTH-1:0];
            end
            if (w_hit_pre) begin
                prescale_d = PWDATA[PRE_WIDTH-1:0];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_hit_duty[i]) begin
                    duty_d[i] = PWDATA[CNT_WIDTH-1:0];
                end
            end
        end
        wrap_d = wrap_q;
        if (w_wr && w_hit_status && PWDATA[0]) begin
            wrap_d = 1'b0;
        end
        if (w_wrap) begin
            wrap_d = 1'b1;
        end
    end

    // The >= compare lets the prescaler recover when PRESCALE drops below the count
    assign w_tick = en_q && (pre_cnt_q >= prescale_q);
    assign w_wrap = w_tick && (cnt_q == period_act_q);
    assign w_load = !en_q || w_wrap;

    always_comb begin
        pre_cnt_d = '0;
        cnt_d     = '0;
        if (en_q) begin
            pre_cnt_d = w_tick ? '0 : pre_cnt_q + PRE_WIDTH'(1);
            if (w_wrap) begin
                cnt_d = '0;
            end else if (w_tick) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end
        period_act_d = w_load ? period_q : period_act_q;
        pwm_d        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            duty_act_d[i] = w_load ? duty_q[i] : duty_act_q[i];
            pwm_d[i]      = en_q & ch_en_q[i] & (cnt_q < duty_act_q[i]);
        end
        irq_d = wrap_q & irq_en_q;
    end

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            en_q         <= 1'b0;
            irq_en_q     <= 1'b0;
            ch_en_q      <= '0;
            period_q     <= '0;
            period_act_q <= '0;
            cnt_q        <= '0;
            prescale_q   <= '0;
            pre_cnt_q    <= '0;
            wrap_q       <= 1'b0;
            irq_q        <= 1'b0;
            pwm_q        <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i]     <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            en_q         <= en_d;
            irq_en_q     <= irq_en_d;
            ch_en_q      <= ch_en_d;
            period_q     <= period_d;
            period_act_q <= period_act_d;
            cnt_q        <= cnt_d;
            prescale_q   <= prescale_d;
            pre_cnt_q    <= pre_cnt_d;
            wrap_q       <= wrap_d;
            irq_q        <= irq_d;
            pwm_q        <= pwm_d;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i]     <= duty_d[i];
                duty_act_q[i] <= duty_act_d[i];
            end
        end
    end

    // Reads return shadow values, zero-extended
    always_comb begin
        PRDATA = '0;
        if (w_rd) begin
            if (w_hit_ctrl) begin
                PRDATA[0]           = en_q;
                PRDATA[1]           = irq_en_q;
                PRDATA[8 +: NUM_CH] = ch_en_q;
            end
            if (w_hit_period) begin
                PRDATA[CNT_WIDTH-1:0] = period_q;
            end
            if (w_hit_pre) begin
                PRDATA[PRE_WIDTH-1:0] = prescale_q;
            end
            if (w_hit_status) begin
                PRDATA[0] = wrap_q;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_hit_duty[i]) begin
                    PRDATA[CNT_WIDTH-1:0] = duty_q[i];
                end
            end
        end
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = w_access & ~w_hit_any;
    assign PWM_OUT = pwm_q;
    assign IRQ     = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_pwm_bank.sv
`default_nettype none
// =============================================================================
// tb_apb_pwm_bank : directed self-checking bench for apb_pwm_bank (NUM_CH=4, CNT_WIDTH=16, PRE_WIDTH=8)
// Rev 1.0
// =============================================================================
module tb_apb_pwm_bank;

    localparam int NUM_CH = 4;
    localparam logic [7:0] c_a_ctrl   = 8'h00;
    localparam logic [7:0] c_a_period = 8'h04;
    localparam logic [7:0] c_a_pre    = 8'h08;
    localparam logic [7:0] c_a_status = 8'h0C;
    localparam logic [7:0] c_a_duty0  = 8'h10;
    localparam int         c_guard    = 200;

    logic              SYSCLK;
    logic              NSYSRESET;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [7:0]        PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [NUM_CH-1:0] PWM_OUT;
    logic              IRQ;

    int total = 0;
    int bad   = 0;

    apb_pwm_bank #(
        .NUM_CH    (NUM_CH),
        .CNT_WIDTH (16),
        .PRE_WIDTH (8)
    ) u_dut (
        .SYSCLK    (SYSCLK),
        .NSYSRESET (NSYSRESET),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .PWM_OUT   (PWM_OUT),
        .IRQ       (IRQ)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        @(posedge SYSCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
        @(posedge SYSCLK); #1;
        PENABLE = 1'b1;
        @(posedge SYSCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data, output logic err);
        @(posedge SYSCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
        @(posedge SYSCLK); #1;
        PENABLE = 1'b1;
        #1;
        data = PRDATA;
        err  = PSLVERR;
        @(posedge SYSCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_read(addr, d, e);
        check_val(tag, d, exp);
    endtask

    // Leaves the bench one sample after PWM_OUT[ch] goes high
    task automatic wait_rise(input int ch);
        int g = 0;
        while (PWM_OUT[ch] === 1'b1 && g < c_guard) begin
            @(posedge SYSCLK); #1; g++;
        end
        while (PWM_OUT[ch] !== 1'b1 && g < 2 * c_guard) begin
            @(posedge SYSCLK); #1; g++;
        end
        check_val("rise_timeout", 32'(g >= 2 * c_guard), 32'd0);
    endtask

    task automatic measure(input int ch, output int hi, output int lo);
        hi = 0;
        lo = 0;
        wait_rise(ch);
        while (PWM_OUT[ch] === 1'b1 && hi < c_guard) begin
            hi++; @(posedge SYSCLK); #1;
        end
        while (PWM_OUT[ch] !== 1'b1 && lo < c_guard) begin
            lo++; @(posedge SYSCLK); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0]       rd;
        logic              err;
        int                hi;
        int                lo;
        int                c;
        logic [NUM_CH-1:0] acc_or;
        logic [NUM_CH-1:0] acc_and;

        NSYSRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        repeat (3) @(posedge SYSCLK);
        #1;
        check_val("rst_pwm", 32'(PWM_OUT), 32'd0);
        check_val("rst_irq", 32'(IRQ), 32'd0);
        check_val("rst_prdata", PRDATA, 32'd0);
        check_val("rst_pslverr", 32'(PSLVERR), 32'd0);
        check_val("pready", 32'(PREADY), 32'd1);
        NSYSRESET = 1'b1;
        read_chk("rst_ctrl", c_a_ctrl, 32'd0);
        read_chk("rst_period", c_a_period, 32'd0);

        // Basic duty: 3 high / 7 low, 2-clock CTRL latency
        apb_write(c_a_pre, 32'd0);
        apb_write(c_a_period, 32'd9);
        apb_write(c_a_duty0, 32'd3);
        apb_write(c_a_duty0 + 8'h04, 32'd0);
        apb_write(c_a_duty0 + 8'h08, 32'd20);
        read_chk("duty2_rd", c_a_duty0 + 8'h08, 32'd20);
        apb_write(c_a_ctrl, 32'h101);
        check_val("ctrl_lat_1clk", 32'(PWM_OUT), 32'd0);
        @(posedge SYSCLK); #1;
        check_val("ctrl_lat_2clk", 32'(PWM_OUT), 32'd1);
        measure(0, hi, lo);
        check_val("basic_hi", 32'(hi), 32'd3);
        check_val("basic_lo", 32'(lo), 32'd7);
        acc_or = '0;
        repeat (20) begin
            @(posedge SYSCLK); #1;
            acc_or = acc_or | PWM_OUT;
        end
        check_val("others_idle", 32'(acc_or[3:1]), 32'd0);

        // Shadowing: write lands during the high phase of the running period
        wait_rise(0);
        apb_write(c_a_duty0, 32'd7);
        check_val("shadow_cur_low", 32'(PWM_OUT[0]), 32'd0);
        @(posedge SYSCLK); #1;
        check_val("shadow_cur_low2", 32'(PWM_OUT[0]), 32'd0);
        read_chk("shadow_rd", c_a_duty0, 32'd7);
        measure(0, hi, lo);
        check_val("shadow_next_hi", 32'(hi), 32'd7);
        check_val("shadow_next_lo", 32'(lo), 32'd3);

        // Extremes: duty 0 is constant low, duty > period is constant high
        apb_write(c_a_ctrl, 32'h701);
        repeat (2) @(posedge SYSCLK);
        acc_or  = '0;
        acc_and = '1;
        repeat (20) begin
            @(posedge SYSCLK); #1;
            acc_or  = acc_or | PWM_OUT;
            acc_and = acc_and & PWM_OUT;
        end
        check_val("duty0_low", 32'(acc_or[1]), 32'd0);
        check_val("duty_over_high", 32'(acc_and[2]), 32'd1);
        check_val("ch3_disabled", 32'(acc_or[3]), 32'd0);

        // Prescale 2: 30-clock period, 21 high / 9 low
        apb_write(c_a_pre, 32'd2);
        measure(0, hi, lo);
        check_val("pre_hi", 32'(hi), 32'd21);
        check_val("pre_lo", 32'(lo), 32'd9);
        apb_write(c_a_pre, 32'd0);

        // Interrupt
        apb_write(c_a_ctrl, 32'h0);
        apb_write(c_a_status, 32'h1);
        read_chk("status_clr0", c_a_status, 32'd0);
        check_val("irq_idle", 32'(IRQ), 32'd0);
        apb_write(c_a_ctrl, 32'h103);
        c = 0;
        while (IRQ !== 1'b1 && c < 40) begin
            @(posedge SYSCLK); #1; c++;
        end
        check_val("irq_first_lat", 32'(c), 32'd11);
        repeat (6) @(posedge SYSCLK);
        #1;
        apb_write(c_a_status, 32'h1);
        read_chk("wrap_set_wins", c_a_status, 32'd1);
        check_val("irq_held", 32'(IRQ), 32'd1);
        wait_rise(0);
        apb_write(c_a_status, 32'h1);
        read_chk("w1c_clear", c_a_status, 32'd0);
        check_val("irq_cleared", 32'(IRQ), 32'd0);

        // APB errors and write masking
        apb_read(8'h40, rd, err);
        check_val("err40_rd", rd, 32'd0);
        check_val("err40_slverr", 32'(err), 32'd1);
        apb_write(8'h40, 32'hFFFF_FFFF);
        read_chk("err40_ctrl", c_a_ctrl, 32'h103);
        read_chk("err40_period", c_a_period, 32'd9);
        read_chk("err40_pre", c_a_pre, 32'd0);
        read_chk("err40_duty0", c_a_duty0, 32'd7);
        apb_read(8'h1C, rd, err);
        check_val("duty3_slverr", 32'(err), 32'd0);
        check_val("duty3_rd", rd, 32'd0);
        apb_read(8'h20, rd, err);
        check_val("past_duty_slverr", 32'(err), 32'd1);
        apb_write(c_a_ctrl, 32'hFFFF_FFFF);
        read_chk("ctrl_mask", c_a_ctrl, 32'h0000_0F03);

        // Asynchronous reset while outputs are high
        repeat (3) @(posedge SYSCLK);
        #1;
        check_val("pre_rst_ch2_high", 32'(PWM_OUT[2]), 32'd1);
        #2;
        NSYSRESET = 1'b0;
        #1;
        check_val("async_rst_pwm", 32'(PWM_OUT), 32'd0);
        check_val("async_rst_irq", 32'(IRQ), 32'd0);
        repeat (2) @(posedge SYSCLK);
        #1;
        NSYSRESET = 1'b1;
        read_chk("post_rst_ctrl", c_a_ctrl, 32'd0);
        read_chk("post_rst_period", c_a_period, 32'd0);
        read_chk("post_rst_pre", c_a_pre, 32'd0);
        read_chk("post_rst_status", c_a_status, 32'd0);
        read_chk("post_rst_duty2", c_a_duty0 + 8'h08, 32'd0);
        acc_or = '0;
        repeat (20) begin
            @(posedge SYSCLK); #1;
            acc_or = acc_or | PWM_OUT;
        end
        check_val("post_rst_idle", 32'(acc_or), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_pwm_bank.md
# apb_pwm_bank

Parametrised APB3 slave PWM generator driving `NUM_CH` independent outputs, such as turret servo and motor lines, from fabric logic behind the MSS APB master. All channels share a programmable prescaler and period counter. Per-channel duty registers are double-buffered, so software updates never produce a runt or glitched pulse. A period-wrap status flag with an optional interrupt lets firmware pace duty updates.

## Interface
Parameters:
- `NUM_CH`, 4: number of PWM channels, 1..8.
- `CNT_WIDTH`, 16: period/duty counter width, 8..32.
- `PRE_WIDTH`, 8: prescaler width, 1..16.

Ports:
- `SYSCLK` in 1: single clock; the APB and all PWM logic run on it.
- `NSYSRESET` in 1: reset, asynchronous, active-low.
- `PSEL` in 1: APB select.
- `PENABLE` in 1: APB access phase.
- `PWRITE` in 1: 1 = write.
- `PADDR` in 8: byte address; only `[7:2]` is decoded.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data; zero-extended; 0 when not reading.
- `PREADY` out 1: tied 1 (zero wait states).
- `PSLVERR` out 1: high during the access phase to an unmapped address.
- `PWM_OUT` out `NUM_CH`: registered PWM outputs.
- `IRQ` out 1: `STATUS.WRAP & CTRL.IRQ_EN`, registered.

## Operation
Register map. Reset value of every register is 0.
- 0x00 `CTRL`: bit0 `EN` (global), bit1 `IRQ_EN`, bits[8+NUM_CH-1:8] `CH_EN`.
- 0x04 `PERIOD`: shadow, `CNT_WIDTH` bits.
- 0x08 `PRESCALE`: `PRE_WIDTH` bits, takes effect immediately.
- 0x0C `STATUS`: bit0 `WRAP`, write-1-to-clear.
- 0x10+4*i `DUTY[i]`: shadow, for i < `NUM_CH`.
- Any other address: `PSLVERR`=1; writes are ignored and the read returns 0.

Access rules:
- A write commits when `PSEL & PENABLE & PWRITE`.
- Register bits above the register width are ignored on write and read back as 0.
- Reads of `PERIOD`/`DUTY` return the shadow value, not the active value.

Prescaler and counter:
- The prescaler counts 0..`PRESCALE` and emits a `tick` when count ≥ `PRESCALE`, then returns to 0.
- The ≥ compare guarantees recovery when `PRESCALE` is lowered below the current count.
- `cnt` advances on `tick`, counting 0..`PERIOD_act`.
- At `cnt == PERIOD_act` with `tick`, `cnt` goes to 0 and that cycle is the "wrap".
- One PWM period is (`PERIOD_act`+1)·(`PRESCALE`+1) clocks.

Shadow registers:
- `PERIOD_act` and `DUTY_act[i]` load from their shadows at each wrap.
- They also load on every cycle while `EN`=0.

Output rule:
- `PWM_OUT[i]` = `EN & CH_EN[i] & (cnt < DUTY_act[i])`.
- Consequences: `DUTY`=0 gives constant low; `DUTY` > `PERIOD_act` gives constant high (100%).

Disable:
- `EN`=0 holds `cnt` and the prescaler at 0, so all outputs are low.
- On the 0→1 transition of `EN`, the first period starts at `cnt`=0 using the shadow values.

`WRAP` flag:
- Set on each wrap.
- A W1C write in the same cycle as a wrap leaves `WRAP` set (set wins).

`PERIOD`=0: `cnt` stays 0 and every tick is a wrap.

## Timing
- Reset (asynchronous, immediate): `PWM_OUT`=0, `IRQ`=0, `PRDATA`=0, `PSLVERR`=0, all counters 0, all registers 0.
- A reset mid-period stops outputs at once. After reset release, operation restarts only when software sets `EN`.
- Register write latency: the value is visible in the register on the clock after the access phase.
- `PWM_OUT` changes 1 clock after the `cnt`/`DUTY_act` edge that causes it.
- `CTRL` changes reach `PWM_OUT` in 2 clocks.
- `IRQ` follows `WRAP` by 1 clock.
- `PRDATA` is combinational during the access phase; no wait states.
- A new `DUTY` or `PERIOD` never affects the period in progress. It is used from the first `cnt`=0 after the next wrap.

## Test plan
- Basic duty: `PRESCALE`=0, `PERIOD`=9, `DUTY[0]`=3, `CTRL`=0x101 → `PWM_OUT[0]` repeats 3 clocks high / 7 clocks low. Other outputs stay 0.
- Shadowing: mid-period write `DUTY[0]`=7 → current period still 3 high; next period 7 high. `PRDATA` reads 7 immediately.
- Extremes and prescale: `DUTY[1]`=0 → constant low. `DUTY[2]`=20 with `PERIOD`=9 → constant high. `PRESCALE`=2 → each period lasts 30 clocks.
- Interrupt: `IRQ_EN`=1 → `WRAP` and `IRQ` assert after the first wrap. A W1C write on the same cycle as a wrap leaves `WRAP`=1. A W1C write on a non-wrap cycle clears it.
- APB errors: read 0x40 → `PSLVERR`=1 and `PRDATA`=0. A write to 0x40 changes no register. Write 0xFFFFFFFF to `CTRL` with `NUM_CH`=4 → reads back 0x00000F03.
- Reset mid-operation: assert `NSYSRESET` while outputs are high → all outputs are 0 asynchronously. After release, all registers read 0 and `PWM_OUT` stays 0 until `EN` is set.
